// File: rtl/vn_col_sched_if.sv
// Scheduler-side bus of the VN column scheduler: frame handshake, VN strobes,
// syndrome input and decoded-frame handshake.
interface vn_col_sched_if #(
    parameter int COL_W  = 4,
    parameter int ITER_W = 4
);
    logic              frm_valid;
    logic              frm_ready;
    logic              vn_issue;
    logic [COL_W-1:0]  rd_col;
    logic              c2v_zero;
    logic              wb_en;
    logic [COL_W-1:0]  wb_col;
    logic              syn_zero;
    logic              dec_valid;
    logic              out_ready;
    logic              converged;
    logic [ITER_W-1:0] iter_cnt;

    modport master (
        input  frm_valid, syn_zero, out_ready,
        output frm_ready, vn_issue, rd_col, c2v_zero, wb_en, wb_col,
               dec_valid, converged, iter_cnt
    );

    modport slave (
        output frm_valid, syn_zero, out_ready,
        input  frm_ready, vn_issue, rd_col, c2v_zero, wb_en, wb_col,
               dec_valid, converged, iter_cnt
    );
endinterface

// File: rtl/vn_col_sched.sv
// Column-layer scheduler for the LDPC variable-node array.
// Walks the column blocks once per iteration, tracks the VN pipeline for
// write-back strobes and runs the iteration loop until the stop condition.
// Optional feature: define EARLY_TERM_EN to stop at the first CHECK that
// sees a zero syndrome; otherwise every frame runs MAX_ITER iterations.
//
//  state | meaning
//  IDLE  | waiting for a frame, frm_ready high
//  RUN   | issuing one column block per cycle
//  DRAIN | waiting for the last column to leave the VN pipeline
//  CHECK | one cycle: count iteration, sample syndrome, decide stop
//  DONE  | decoded frame held until downstream accepts it
module vn_col_sched #(
    parameter int COL_BLKN = 12,
    parameter int COL_W    = 4,
    parameter int MAX_ITER = 10,
    parameter int ITER_W   = 4,
    parameter int VN_LAT   = 4
) (
    input  logic               clk,
    input  logic               rst,
    vn_col_sched_if.master     bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q;
    logic [ITER_W-1:0] iter_q;
    logic              conv_q;
    logic [COL_W:0]    pipe_q [VN_LAT];

    logic              accept;
    logic              issue;
    logic              col_last;
    logic              wb_en;
    logic [COL_W-1:0]  wb_col;
    logic              last_wb;
    logic              last_iter;
    logic              stop;

    assign accept    = (state_q == S_IDLE) && bus.frm_valid;
    assign issue     = (state_q == S_RUN);
    assign col_last  = (col_q == COL_W'(COL_BLKN - 1));
    assign wb_en     = pipe_q[VN_LAT-1][COL_W];
    assign wb_col    = pipe_q[VN_LAT-1][COL_W-1:0];
    assign last_wb   = wb_en && (wb_col == COL_W'(COL_BLKN - 1));
    assign last_iter = (iter_q == ITER_W'(MAX_ITER - 1));
`ifdef EARLY_TERM_EN
    assign stop      = last_iter || bus.syn_zero;
`else
    assign stop      = last_iter;
`endif

    // State register; async reset drops any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)        state_d = S_RUN;
            S_RUN:   if (col_last)      state_d = S_DRAIN;
            S_DRAIN: if (last_wb)       state_d = S_CHECK;
            S_CHECK: state_d = stop ? S_DONE : S_RUN;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Column and iteration counters plus the registered convergence flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            iter_q <= '0;
            conv_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    col_q  <= '0;
                    iter_q <= '0;
                    conv_q <= 1'b0;
                end
                S_RUN:   col_q <= col_last ? '0 : col_q + 1'b1;
                S_CHECK: begin
                    col_q  <= '0;
                    iter_q <= iter_q + 1'b1;
                    conv_q <= bus.syn_zero;
                end
                default: ;
            endcase
        end
    end

    // VN pipeline shadow: {issue, col} delayed by VN_LAT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VN_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {issue, col_q};
            for (int i = 1; i < VN_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign bus.frm_ready = (state_q == S_IDLE);
    assign bus.vn_issue  = issue;
    assign bus.rd_col    = col_q;
    assign bus.c2v_zero  = issue && (iter_q == '0);
    assign bus.wb_en     = wb_en;
    assign bus.wb_col    = wb_col;
    assign bus.dec_valid = (state_q == S_DONE);
    assign bus.converged = conv_q;
    assign bus.iter_cnt  = iter_q;

endmodule

// File: tb/tb_vn_col_sched.sv
// Self-checking bench for vn_col_sched. Instance A uses default parameters,
// instance B uses MAX_ITER=1. Expected strobes come from the per-iteration
// timeline (column phase within a COL_BLKN+VN_LAT+1 cycle iteration).
module tb_vn_col_sched;

    localparam int NCOL = 12;
    localparam int LAT  = 4;
    localparam int MAXI = 10;
    localparam int PER  = NCOL + LAT + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    vn_col_sched_if #(.COL_W(4), .ITER_W(4)) ifa ();
    vn_col_sched_if #(.COL_W(4), .ITER_W(4)) ifb ();

    vn_col_sched #(.COL_BLKN(NCOL), .COL_W(4), .MAX_ITER(MAXI), .ITER_W(4), .VN_LAT(LAT))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.master));

    vn_col_sched #(.COL_BLKN(NCOL), .COL_W(4), .MAX_ITER(1), .ITER_W(4), .VN_LAT(LAT))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
        end
    endtask

    function automatic logic [12:0] act_vec();
        logic [3:0] rd, wc;
        rd = ifa.vn_issue ? ifa.rd_col : 4'd0;
        wc = ifa.wb_en    ? ifa.wb_col : 4'd0;
        return {ifa.frm_ready, ifa.dec_valid, ifa.vn_issue, ifa.c2v_zero, ifa.wb_en, rd, wc};
    endfunction

    // Caller is at #1 inside an IDLE cycle; returns at #1 inside the next IDLE cycle.
    task automatic run_frame(input logic [15:0] plan, input int hold);
        int         n_it;
        logic       exp_conv;
        int         it, p;
        logic       e_iss, e_wb;
        logic [3:0] e_rd, e_wc;
        n_it = MAXI;
`ifdef EARLY_TERM_EN
        for (int k = MAXI - 1; k >= 0; k--) if (plan[k]) n_it = k + 1;
`endif
        exp_conv = plan[n_it-1];

        ifa.frm_valid = 1'b1;
        chk("idle_ready", {31'd0, ifa.frm_ready}, 32'd1);
        @(posedge clk); #1;
        chk("iter_clr", {28'd0, ifa.iter_cnt}, 32'd0);
        chk("conv_clr", {31'd0, ifa.converged}, 32'd0);

        for (int c = 0; c < n_it * PER; c++) begin
            it = c / PER;
            p  = c % PER;
            ifa.frm_valid = 1'($urandom_range(0, 1));
            ifa.out_ready = 1'($urandom_range(0, 1));
            ifa.syn_zero  = (p == PER - 1) ? plan[it] : 1'($urandom_range(0, 1));
            e_iss = (p < NCOL);
            e_wb  = (p >= LAT) && (p < NCOL + LAT);
            e_rd  = e_iss ? 4'(p) : 4'd0;
            e_wc  = e_wb ? 4'(p - LAT) : 4'd0;
            chk("run_cyc", {19'd0, act_vec()},
                {19'd0, 1'b0, 1'b0, e_iss, e_iss && (it == 0), e_wb, e_rd, e_wc});
            @(posedge clk); #1;
        end

        ifa.out_ready = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            chk("done_hold", {22'd0, ifa.frm_ready, ifa.dec_valid, ifa.vn_issue, ifa.wb_en,
                              ifa.iter_cnt, ifa.converged},
                {22'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(n_it), exp_conv});
            if (h < hold) begin
                ifa.frm_valid = 1'($urandom_range(0, 1));
                ifa.syn_zero  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        ifa.frm_valid = 1'b0;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
        chk("released", {26'd0, ifa.frm_ready, ifa.dec_valid, ifa.iter_cnt},
            {26'd0, 1'b1, 1'b0, 4'(n_it)});
    endtask

    task automatic reset_mid(input int k);
        ifa.frm_valid = 1'b1;
        @(posedge clk); #1;
        ifa.frm_valid = 1'b0;
        repeat (k) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("rst_async", {28'd0, ifa.vn_issue, ifa.wb_en, ifa.frm_ready, ifa.dec_valid},
            {28'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post_rst", {29'd0, ifa.vn_issue, ifa.wb_en, ifa.frm_ready},
                {29'd0, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic run_b(input logic syn);
        ifb.syn_zero  = syn;
        ifb.frm_valid = 1'b1;
        @(posedge clk); #1;
        ifb.frm_valid = 1'b0;
        for (int c = 0; c < PER; c++) begin
            chk("b_busy", {31'd0, ifb.dec_valid}, 32'd0);
            @(posedge clk); #1;
        end
        chk("b_done", {27'd0, ifb.dec_valid, ifb.iter_cnt}, {27'd0, 1'b1, 4'd1});
        chk("b_conv", {31'd0, ifb.converged}, {31'd0, syn});
        ifb.out_ready = 1'b1;
        @(posedge clk); #1;
        ifb.out_ready = 1'b0;
        chk("b_idle", {31'd0, ifb.frm_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] plan;
        ifa.frm_valid = 1'b0; ifa.syn_zero = 1'b0; ifa.out_ready = 1'b0;
        ifb.frm_valid = 1'b0; ifb.syn_zero = 1'b0; ifb.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {19'd0, act_vec()}, {19'd0, 13'b1_0000_0000_0000});
        chk("reset_misc", {27'd0, ifa.converged, ifa.iter_cnt}, 32'd0);
        chk("reset_b", {31'd0, ifb.frm_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(16'h0000, 20);
        run_frame(16'h0200, 0);
        reset_mid(6);
        run_frame(16'h0004, 3);
        run_frame(16'h0001, 1);
        for (int f = 0; f < 4; f++) begin
            plan = 16'($urandom_range(0, 1023));
            run_frame(plan, $urandom_range(0, 20));
        end
        reset_mid($urandom_range(13, 15));
        run_frame(16'($urandom_range(0, 1023)), 2);

        run_b(1'b1);
        run_b(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
